// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out shifter for the UART TX datapath. A word and its
// frame length are taken over a valid/ready handshake, then shifted out one
// bit per ser_en tick. A new word can be accepted on the same edge the last
// bit of the current frame retires, so back-to-back frames have no gap.
//
// Parameters:
//   DATA_WIDTH  maximum word width in bits (>= 2)
//   MSB_FIRST   0: P_DATA[0] goes out first, 1: P_DATA[DATA_WIDTH-1] first
//   IDLE_LEVEL  level driven on ser_data while no frame is active
//   CNT_WIDTH   width of the bit counter and of LEN
//
// Ports:
//   CLK         clock, rising edge
//   RST         synchronous active-high reset
//   P_DATA      parallel word, sampled only on an accepted load
//   LEN         frame length in bits (0 or > DATA_WIDTH means DATA_WIDTH)
//   load_valid  source presents a word on P_DATA/LEN
//   load_ready  word can be accepted this cycle (combinational)
//   ser_en      bit-advance tick; the current bit retires on an edge with 1
//   ser_data    serial bit (registered)
//   ser_done    one-cycle pulse after the last bit of a frame retires
//   busy        a frame is being shifted (registered)
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic [CNT_WIDTH-1:0]  LEN,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] FULL_LEN = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                  state_reg,    state_next;
  logic [DATA_WIDTH-1:0]   shift_reg,    shift_next;
  logic [CNT_WIDTH-1:0]    cnt_reg,      cnt_next;
  logic [CNT_WIDTH-1:0]    len_reg,      len_next;
  logic                    ser_data_reg, ser_data_next;
  logic                    done_reg,     done_next;
  logic                    busy_reg,     busy_next;

  // Word rearranged so that the first bit to transmit sits at index 0. The
  // shifter then always shifts right regardless of bit order, and a short
  // MSB-first frame naturally sends P_DATA[DATA_WIDTH-1] down to
  // P_DATA[DATA_WIDTH-len].
  logic [DATA_WIDTH-1:0]   ordered_word;

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign ordered_word[gi] = P_DATA[DATA_WIDTH-1-gi];
      end else begin : g_lsb
        assign ordered_word[gi] = P_DATA[gi];
      end
    end
  endgenerate

  // A zero or oversized length means a full-width frame.
  logic [CNT_WIDTH-1:0] len_clamped;
  assign len_clamped = ((LEN == '0) || (LEN > FULL_LEN)) ? FULL_LEN : LEN;

  // The last bit retires on this edge.
  logic last_bit;
  assign last_bit = (state_reg == SHIFT) && ser_en && (cnt_reg == len_reg - CNT_ONE);

  logic accept;
  assign load_ready = (state_reg == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      cnt_reg      <= '0;
      len_reg      <= '0;
      ser_data_reg <= IDLE_LEVEL;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      cnt_reg      <= cnt_next;
      len_reg      <= len_next;
      ser_data_reg <= ser_data_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    cnt_next      = cnt_reg;
    len_next      = len_reg;
    ser_data_next = ser_data_reg;
    done_next     = 1'b0;
    busy_next     = busy_reg;

    case (state_reg)
      IDLE: begin
        // ser_en is irrelevant here: bit 0 appears on the next cycle and is
        // held until the first tick seen in SHIFT.
        if (accept) begin
          state_next    = SHIFT;
          shift_next    = ordered_word;
          cnt_next      = '0;
          len_next      = len_clamped;
          ser_data_next = ordered_word[0];
          busy_next     = 1'b1;
        end
      end

      SHIFT: begin
        if (ser_en) begin
          if (cnt_reg == len_reg - CNT_ONE) begin
            done_next = 1'b1;
            if (accept) begin
              // Chain straight into the next word with no idle cycle.
              shift_next    = ordered_word;
              cnt_next      = '0;
              len_next      = len_clamped;
              ser_data_next = ordered_word[0];
              busy_next     = 1'b1;
            end else begin
              state_next    = IDLE;
              ser_data_next = IDLE_LEVEL;
              busy_next     = 1'b0;
            end
          end else begin
            shift_next    = shift_reg >> 1;
            cnt_next      = cnt_reg + CNT_ONE;
            ser_data_next = shift_reg[1];
          end
        end
      end

      default: begin
        state_next    = IDLE;
        ser_data_next = IDLE_LEVEL;
        busy_next     = 1'b0;
      end
    endcase
  end

  assign ser_data = ser_data_reg;
  assign ser_done = done_reg;
  assign busy     = busy_reg;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shifter for the UART TX datapath. Generalises the fixed 8-bit serializer.
- Adds a valid/ready load handshake, a runtime frame length, selectable bit order and a tick-gated bit rate.
- Supports back-to-back words with zero idle cycles.
- Sits between the TX FSM/FIFO (word source) and the TX output mux. ser_en is driven by the baud tick.

Parameters:
- DATA_WIDTH, 8: maximum word width in bits (≥2).
- MSB_FIRST, 0: 0 = shift bit 0 first; 1 = shift bit DATA_WIDTH-1 first.
- IDLE_LEVEL, 0: value driven on ser_data when no frame is active.
- CNT_WIDTH, $clog2(DATA_WIDTH+1): width of the bit counter and of LEN.

Ports:
- CLK  input  1  sole clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel word; sampled only on an accepted load.
- LEN  input  CNT_WIDTH  frame length in bits; sampled with P_DATA.
- load_valid  input  1  source has a word on P_DATA/LEN.
- load_ready  output  1  serializer can accept a word this cycle (combinational).
- ser_en  input  1  bit-advance tick; the current bit retires on an edge where ser_en=1.
- ser_data  output  1  serial bit, registered.
- ser_done  output  1  one-cycle pulse, registered, after the last bit of a frame retires.
- busy  output  1  a frame is being shifted, registered.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. RST has priority over every other input.
- Reset values: state=IDLE, ser_data=IDLE_LEVEL, ser_done=0, busy=0, shift register=0, counter=0, len_reg=0.
- Reset mid-frame aborts the frame: no ser_done pulse, and load_ready=1 in the cycle after reset is released.
- States: IDLE and SHIFT.
- load_ready = (state==IDLE) OR (state==SHIFT AND ser_en AND counter==len_reg-1).
- Accept: load_valid AND load_ready at an edge. On accept:
  - capture P_DATA into the shift register;
  - len_reg = DATA_WIDTH if LEN==0 or LEN>DATA_WIDTH, otherwise LEN;
  - counter=0, state=SHIFT.
- Latency: with an accept at edge t, ser_data shows bit 0 of the frame and busy=1 from t+1. Bit 0 is P_DATA[0] if MSB_FIRST=0, or P_DATA[DATA_WIDTH-1] if MSB_FIRST=1.
- Short frames with MSB_FIRST=1: transmit P_DATA[DATA_WIDTH-1] down to P_DATA[DATA_WIDTH-len_reg]. With MSB_FIRST=0: transmit P_DATA[0] up to P_DATA[len_reg-1].
- SHIFT, ser_en=0: ser_data holds, counter holds.
- SHIFT, ser_en=1, counter<len_reg-1: shift, counter+1, ser_data = next bit.
- SHIFT, ser_en=1, counter==len_reg-1 (last bit retires):
  - ser_done=1 in the following cycle only;
  - if a word is accepted on the same edge: state stays SHIFT, ser_data = bit 0 of the new word, busy stays 1 (no gap);
  - otherwise: state=IDLE, ser_data=IDLE_LEVEL, busy=0.
- ser_en in IDLE, or on the accept edge from IDLE, is ignored. Bit 0 always lasts at least until the first ser_en after it appears.
- load_valid while load_ready=0 is ignored. The producer holds P_DATA, LEN and load_valid until accepted.
- P_DATA/LEN changes during SHIFT have no effect on the frame in flight.
- Counter never exceeds len_reg-1; no wrap-around is possible.

Test Plan:
1. Bit order and latency: MSB_FIRST=0, P_DATA=0xD2, LEN=0, ser_en=1 every cycle, accept at t.
   - ser_data = 0,1,0,0,1,0,1,1 at t+1..t+8.
   - busy=1 at t+1..t+8; ser_done=1 only at t+9; ser_data=IDLE_LEVEL at t+9.
2. MSB-first: MSB_FIRST=1, same stimulus as test 1.
   - ser_data = 1,1,0,1,0,0,1,0 at t+1..t+8; ser_done at t+9.
3. Tick-gated rate: ser_en high every 4th cycle, P_DATA=0xD2.
   - Each bit held exactly 4 cycles (the first bit may be held 1-4 cycles depending on tick phase).
   - ser_done pulses once, 1 cycle wide.
   - load_valid asserted mid-frame sees load_ready=0 until the 8th tick.
4. Frame length:
   - LEN=5, P_DATA=0xFF, LSB-first: five 1s, then IDLE_LEVEL, ser_done after the 5th tick.
   - LEN=12: 8 bits sent (clamped).
   - LEN=0: 8 bits sent.
5. Back-to-back: load_valid held continuously with 0x55 then 0xAA, ser_en=1.
   - load_ready=1 in IDLE and in the 8th-bit cycle only.
   - 16 consecutive data bits, no IDLE_LEVEL cycle between words.
   - ser_done=1 coincides with bit 0 of 0xAA, and pulses again after 0xAA.
6. Reset mid-frame: RST=1 while bit 3 is displayed.
   - Next cycle: ser_data=IDLE_LEVEL, busy=0, ser_done=0, load_ready=1.
   - No ser_done pulse for the aborted frame.
   - A new word after reset is serialised correctly from bit 0.
